// File: rtl/serial_flag_framer_tx.sv
// Flag-framed, bit-stuffed serial transmitter: parallel words in, one bit per cycle out.
// Optional even-parity bit per word when SERIAL_FRAMER_PARITY_EN is defined.
module serial_flag_framer_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              busy
);

`ifdef SERIAL_FRAMER_PARITY_EN
  localparam int unsigned NB = DATA_W + 1;
`else
  localparam int unsigned NB = DATA_W;
`endif
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FLAG_END = CNT_W'(4);
  localparam logic [CNT_W-1:0] WORD_END = CNT_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SFLAG, S_DATA, S_STUFF, S_GAP, S_EFLAG
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_full_q, hold_full_d;
  logic [NB-1:0]     shift_q, shift_d;
  logic              word_last_q, word_last_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]        ones_q, ones_d;
  logic              eow_q, eow_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_valid_q, tx_valid_d;

  logic              load;
  logic              eow_go;
  logic              word_end;
  logic [NB-1:0]     load_word;

`ifdef SERIAL_FRAMER_PARITY_EN
  assign load_word = {^hold_data_q, hold_data_q};
`else
  assign load_word = hold_data_q;
`endif

  assign word_end = (bit_cnt_q == WORD_END);
  assign in_ready = !hold_full_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      word_last_q <= 1'b0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      eow_q       <= 1'b0;
      tx_bit_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      word_last_q <= word_last_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      eow_q       <= eow_d;
      tx_bit_q    <= tx_bit_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    word_last_d = word_last_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    eow_d       = eow_q;
    load        = 1'b0;
    eow_go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          state_d   = S_SFLAG;
          bit_cnt_d = '0;
        end
      end
      S_SFLAG: begin
        if (bit_cnt_q == FLAG_END) begin
          ones_d  = '0;
          load    = 1'b1;
          state_d = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (shift_q[0] && ones_q == 2'd1) begin
          // eow_q remembers whether the stuff bit interrupted the word's final bit
          ones_d  = 2'd2;
          eow_d   = word_end;
          state_d = S_STUFF;
        end else begin
          ones_d = shift_q[0] ? ones_q + 2'd1 : 2'd0;
          eow_go = word_end;
        end
      end
      S_STUFF: begin
        ones_d = '0;
        if (eow_q) eow_go = 1'b1;
        else       state_d = S_DATA;
      end
      S_GAP: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_DATA;
        end
      end
      S_EFLAG: begin
        if (bit_cnt_q == FLAG_END) state_d = S_IDLE;
        else                       bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (eow_go) begin
      if (word_last_q) begin
        state_d   = S_EFLAG;
        bit_cnt_d = '0;
      end else if (hold_full_q) begin
        load    = 1'b1;
        state_d = S_DATA;
      end else begin
        state_d = S_GAP;
      end
    end

    if (load) begin
      shift_d     = load_word;
      word_last_d = hold_last_q;
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      hold_data_d = in_data;
      hold_last_d = in_last;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    tx_valid_d = 1'b0;
    tx_bit_d   = 1'b0;
    case (state_q)
      S_SFLAG, S_EFLAG: begin
        tx_valid_d = 1'b1;
        tx_bit_d   = (bit_cnt_q != '0) && (bit_cnt_q != FLAG_END);
      end
      S_DATA: begin
        tx_valid_d = 1'b1;
        tx_bit_d   = shift_q[0];
      end
      S_STUFF: tx_valid_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_flag_framer_tx.sv
// Bench for serial_flag_framer_tx: fixed single-word frame table, corner sequences,
// and random multi-word frames checked against a bit-stuffing stream model.
module tb_serial_flag_framer_tx;
  localparam int unsigned DATA_W = 8;
`ifdef SERIAL_FRAMER_PARITY_EN
  localparam int unsigned NBITS = DATA_W + 1;
`else
  localparam int unsigned NBITS = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              busy;

  int checks = 0;
  int errors = 0;
  bit rx_q[$];
  bit exp_q[$];
  int flen[$];
  int runs = 0;
  bit prev_valid = 1'b0;
  int ones_run = 0;

  typedef struct {
    logic [7:0]  data;
    int          len;
    logic [31:0] field;
  } vec_t;
  vec_t vecs[7];

  serial_flag_framer_tx #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .tx_bit(tx_bit),
    .tx_valid(tx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // collects every valid bit and counts contiguous valid runs
  initial forever begin
    @(negedge clk);
    if (tx_valid === 1'b1) begin
      rx_q.push_back(tx_bit);
      if (!prev_valid) runs++;
    end
    prev_valid = (tx_valid === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_stream(input string name);
    bit ok;
    string sa, se;
    ok = (rx_q.size() == exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] != exp_q[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      sa = ""; se = "";
      for (int i = 0; i < rx_q.size() && i < 200; i++) sa = {sa, rx_q[i] ? "1" : "0"};
      for (int i = 0; i < exp_q.size() && i < 200; i++) se = {se, exp_q[i] ? "1" : "0"};
      $display("FAIL %s: got %s expected %s", name, sa, se);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int k = 0;
    step();
    in_data = d; in_last = l; in_valid = 1'b1;
    while (in_ready !== 1'b1 && k < 300) begin step(); k++; end
    check("send_accept_timeout", (in_ready === 1'b1), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 500) begin step(); k++; end
    check("wait_bits_timeout", (rx_q.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(busy === 1'b0 && tx_valid === 1'b0 && in_ready === 1'b1) && k < 2000) begin
      step(); k++;
    end
    check("wait_idle_timeout", (k < 2000), 1);
  endtask

  task automatic push_flag();
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
  endtask

  // stream model: data bits LSB first (plus parity), a 0 after every 2nd consecutive 1
  task automatic model_word(input logic [7:0] w);
    bit b;
    for (int unsigned i = 0; i < NBITS; i++) begin
      if (i < DATA_W) b = w[i];
      else            b = ^w;
      exp_q.push_back(b);
      ones_run = b ? ones_run + 1 : 0;
      if (ones_run == 2) begin
        exp_q.push_back(1'b0);
        ones_run = 0;
      end
    end
  endtask

  task automatic clear_capture();
    rx_q.delete(); exp_q.delete(); runs = 0;
  endtask

  initial begin
    int n0, off, bad, nw;
    logic [7:0] d;
`ifdef SERIAL_FRAMER_PARITY_EN
    vecs[0] = '{8'h00,  9, 32'b000000000};
    vecs[1] = '{8'hFF, 13, 32'b1101101101100};
    vecs[2] = '{8'h03, 10, 32'b1100000000};
    vecs[3] = '{8'h55,  9, 32'b101010100};
    vecs[4] = '{8'hB6, 12, 32'b011001100110};
    vecs[5] = '{8'h80, 10, 32'b0000000110};
    vecs[6] = '{8'h07, 10, 32'b1101000001};
`else
    vecs[0] = '{8'h00,  8, 32'b00000000};
    vecs[1] = '{8'hFF, 12, 32'b110110110110};
    vecs[2] = '{8'h03,  9, 32'b110000000};
    vecs[3] = '{8'h55,  8, 32'b10101010};
    vecs[4] = '{8'hB6, 10, 32'b0110011001};
    vecs[5] = '{8'h80,  8, 32'b00000001};
    vecs[6] = '{8'h07,  9, 32'b110100000};
`endif
    reset = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_tx_bit", tx_bit, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);

    // latency from IDLE and end-of-frame busy
    clear_capture();
    send(8'h00, 1'b1);
    step();
    check("lat_e0_busy", busy, 0);
    check("lat_e0_in_ready", in_ready, 0);
    step();
    check("lat_e1_busy", busy, 1);
    check("lat_e1_tx_valid", tx_valid, 0);
    step();
    check("lat_e2_tx_valid", tx_valid, 1);
    check("lat_e2_tx_bit", tx_bit, 0);
    wait_bits(10 + NBITS);
    check("lat_last_bit_busy", busy, 0);
    wait_idle();
    push_flag(); ones_run = 0; model_word(8'h00); push_flag();
    check_stream("lat_stream");
    check("lat_runs", runs, 1);

    for (int v = 0; v < 7; v++) begin
      clear_capture();
      send(vecs[v].data, 1'b1);
      wait_idle();
      push_flag();
      for (int i = vecs[v].len - 1; i >= 0; i--) exp_q.push_back(vecs[v].field[i]);
      push_flag();
      check_stream($sformatf("vec_%02h_stream", vecs[v].data));
      check($sformatf("vec_%02h_len", vecs[v].data), rx_q.size(), 10 + vecs[v].len);
      check($sformatf("vec_%02h_runs", vecs[v].data), runs, 1);
    end

    // back-to-back words: stuffing carries across the word boundary
    clear_capture();
    send(8'h80, 1'b0);
    send(8'h01, 1'b1);
    wait_idle();
    push_flag(); ones_run = 0; model_word(8'h80); model_word(8'h01); push_flag();
    check_stream("xword_stream");
    check("xword_runs", runs, 1);

    // underrun: GAP holds ones_cnt, in_ready stays high
    clear_capture();
    send(8'h80, 1'b0);
    wait_bits(5 + DATA_W);
    n0 = 0;
    while (tx_valid === 1'b1 && n0 < 50) begin step(); n0++; end
    check("gap_tx_valid", tx_valid, 0);
    check("gap_in_ready", in_ready, 1);
    check("gap_busy", busy, 1);
    step();
    check("gap_tx_valid_2", tx_valid, 0);
    check("gap_in_ready_2", in_ready, 1);
    send(8'h01, 1'b1);
    wait_idle();
    push_flag(); ones_run = 0; model_word(8'h80); model_word(8'h01); push_flag();
    check_stream("gap_stream");
    check("gap_runs", runs, 2);

    // reset mid-DATA with a word waiting in the holding register
    clear_capture();
    send(8'hFF, 1'b0);
    send(8'h00, 1'b1);
    wait_bits(8);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    n0 = rx_q.size();
    repeat (30) step();
    check("rst_no_more_bits", rx_q.size(), n0);
    clear_capture();
    send(8'h55, 1'b1);
    wait_idle();
    push_flag(); ones_run = 0; model_word(8'h55); push_flag();
    check_stream("rst_new_frame");
    check("rst_new_runs", runs, 1);

    // random multi-word frames with random producer stalls
    clear_capture();
    flen.delete();
    for (int f = 0; f < 12; f++) begin
      nw = $urandom_range(1, 4);
      n0 = exp_q.size();
      push_flag(); ones_run = 0;
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 3)) step();
        d = 8'($urandom);
        send(d, (w == nw - 1));
        model_word(d);
      end
      push_flag();
      flen.push_back(exp_q.size() - n0);
    end
    wait_idle();
    check("rand_total_len", rx_q.size(), exp_q.size());
    off = 0;
    foreach (flen[f]) begin
      bad = 0;
      for (int i = 0; i < flen[f]; i++)
        if (off + i >= rx_q.size() || rx_q[off + i] != exp_q[off + i]) bad++;
      check($sformatf("rand_frame%0d_bad_bits", f), bad, 0);
      off += flen[f];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
